// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types
// Contents: word_t    32-bit data/address word
//           ramstate_t RAM handshake state (FREE, BUSY, ACCESS, ERROR)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter onto a single-port RAM
// Ports: CLK, nRST            clock (rising edge), async active-low reset
//        iREN, iaddr          icache read request / word address
//        iwait, iload         icache stall (0 on completion) / read data
//        dREN, dWEN           dcache read / write request
//        daddr, dstore        dcache word address / write data
//        dwait, dload         dcache stall (0 on completion) / read data
//        ramREN, ramWEN       RAM read / write strobe
//        ramaddr, ramstore    RAM address / write data
//        ramload, ramstate    RAM read data / handshake state
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arb_state_t;

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          d_req;
    logic          starved;

    assign d_req   = dREN | dWEN;
    assign starved = (starve_cnt == STARVE_LIM) && iREN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Outputs are purely combinational from state and inputs; since the
    // state register resets asynchronously to IDLE, every output sits at
    // its reset value for as long as nRST is low.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;

        case (state)
            IDLE: begin
                if (d_req && !starved) begin
                    state_nxt = DSERV;
                    if (iREN && (starve_cnt != STARVE_LIM))
                        starve_nxt = starve_cnt + CW'(1);
                end else if (iREN) begin
                    state_nxt  = ISERV;
                    starve_nxt = '0;
                end
                if (!iREN)
                    starve_nxt = '0;
            end

            DSERV: begin
                // A withdrawn request drops the strobes at once and never acks.
                if (!d_req) begin
                    state_nxt = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (ramstate == ACCESS) begin
                        dwait     = 1'b0;
                        dload     = ramload;
                        state_nxt = IDLE;
                    end
                end
            end

            ISERV: begin
                if (!iREN) begin
                    state_nxt = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ramstate == ACCESS) begin
                        iwait     = 1'b0;
                        iload     = ramload;
                        state_nxt = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive dcache grants while an icache request is pending.
REQ-002 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-003 SHALL have port nRST  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port iREN  in  1  icache read request.
REQ-005 SHALL have port iaddr  in  32  icache word address.
REQ-006 SHALL have port iwait  out  1  icache stall; 0 for exactly the cycle iload is valid.
REQ-007 SHALL have port iload  out  32  icache read data.
REQ-008 SHALL have ports dREN / dWEN  in  1 each  dcache read / write request.
REQ-009 SHALL have port daddr  in  32  dcache word address (block-aligned pairs at offsets 0x0 and 0x4).
REQ-010 SHALL have port dstore  in  32  dcache write data.
REQ-011 SHALL have port dwait  out  1  dcache stall; 0 for exactly the cycle the word completes.
REQ-012 SHALL have port dload  out  32  dcache read data.
REQ-013 SHALL have ports ramREN / ramWEN  out  1 each  RAM read / write strobe.
REQ-014 SHALL have ports ramaddr / ramstore  out  32 each  RAM address / write data.
REQ-015 SHALL have port ramload  in  32  RAM read data.
REQ-016 SHALL have port ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Function
REQ-017 SHALL implement the FSM states IDLE, DSERV and ISERV, with one registered owner per word transfer.
REQ-018 In IDLE, the block SHALL drive no RAM strobe and SHALL arbitrate; the next state SHALL be DSERV if (dREN|dWEN) and not starved, ISERV if iREN, otherwise IDLE.
REQ-019 Starved SHALL mean starve_cnt == STARVE_MAX with iREN high; in that case ISERV SHALL be chosen even when dcache requests.
REQ-020 starve_cnt SHALL increment, saturating at STARVE_MAX, on each IDLE->DSERV while iREN=1, and SHALL clear on IDLE->ISERV or whenever iREN=0 in IDLE.
REQ-021 In DSERV, the block SHALL route ramaddr=daddr and ramstore=dstore combinationally, with ramWEN=dWEN and ramREN=dREN&~dWEN; if both are set, the write wins.
REQ-022 In ISERV, the block SHALL drive ramREN=1, ramWEN=0 and ramaddr=iaddr.
REQ-023 In any SERV state with ramstate==ACCESS, the owner's wait SHALL be 0 that cycle, the owner's load SHALL equal ramload, and next state SHALL be IDLE.
REQ-024 With ramstate FREE, BUSY or ERROR, the owner's wait SHALL stay 1 and the state SHALL be held.
REQ-025 The non-owner's wait SHALL always be 1.
REQ-026 If the owner withdraws its request mid-service, the block SHALL deassert RAM strobes that same cycle, SHALL return to IDLE, and SHALL issue no ack.
REQ-027 Minimum latency SHALL be 2 cycles: request seen in IDLE at cycle N, wait low at N+1 if RAM answers ACCESS immediately.
REQ-028 A two-word dcache block transfer SHALL take two arbitrations; icache MAY be granted between the words only when starved.
REQ-029 In IDLE, iload and dload SHALL be 0.
REQ-030 In IDLE, iwait and dwait SHALL be 1.

Reset
REQ-031 While nRST=0, the block SHALL force: state=IDLE, starve_cnt=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
REQ-032 Reset asserted mid-transfer SHALL abort it with no ack; the first request after release SHALL be arbitrated afresh.

Structure
REQ-033 ramstate_t and word_t SHALL come from cpu_types_pkg.
REQ-034 The arbiter state enum SHALL be local to the module.
REQ-035 The block SHALL be a single module with no sub-modules.

Verification
REQ-036 The bench SHALL cover: dREN=1, daddr=0x100, RAM ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> dwait low exactly cycle 3, dload=0xDEADBEEF, ramREN high cycles 1-3.
REQ-037 The bench SHALL cover: iREN and dWEN simultaneous, daddr=0x200, dstore=0x1234 -> dcache served first, with ramWEN=1 and ramstore=0x1234; icache served next.
REQ-038 The bench SHALL cover: dcache requesting continuously with iREN held and STARVE_MAX=4 -> 4 dcache grants, then 1 icache grant, then the counter cleared.
REQ-039 The bench SHALL cover: dREN=dWEN=1 -> ramWEN=1 and ramREN=0.
REQ-040 The bench SHALL cover: dREN dropped while in DSERV with ramstate=BUSY -> strobes low the same cycle, IDLE next cycle, dwait never 0.
REQ-041 The bench SHALL cover: nRST pulsed low during ISERV -> all outputs at reset values immediately; a new iREN after release is served with 2-cycle minimum latency.
